// File: rtl/demux_pkg.sv
// Shared types and helpers for the registered 1-to-4 demultiplexer.
package demux_pkg;

  localparam int unsigned DEMUX_CH_NUM = 4;

  typedef logic [1:0]              demux_key_t;
  typedef logic [DEMUX_CH_NUM-1:0] demux_vec_t;

  // One-hot channel select from a destination key.
  function automatic demux_vec_t demux_onehot(input demux_key_t key);
    return demux_vec_t'(1) << key;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output register slot: holds a beat until its consumer takes it.
module demux_slot #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  load_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  ready_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] val_o,
  output logic                  free_o
);

  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] val_q, val_d;

  // Load wins over drain so a drain+load cycle keeps the slot full with new data.
  always_comb begin
    valid_d = valid_q;
    val_d   = val_q;
    if (load_i) begin
      valid_d = 1'b1;
      val_d   = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  // Slot registers; reset discards any held beat.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      val_q   <= '0;
    end else begin
      valid_q <= valid_d;
      val_q   <= val_d;
    end
  end

  // Free when empty, or when the current beat leaves this cycle.
  assign free_o  = ~valid_q | ready_i;
  assign valid_o = valid_q;
  assign val_o   = val_q;

endmodule

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with valid/ready handshake and broadcast.
// Optional per-channel drain counters: define DEMUX_1TO4_CNT_EN.
module demux_1to4_reg
  import demux_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  output logic                       o_ready,
  input  logic [1:0]                 i_key,
  input  logic                       i_bcast,
  input  logic [DATA_WIDTH-1:0]      i_val,
  output logic [3:0]                 o_valid,
  input  logic [3:0]                 i_ready,
`ifdef DEMUX_1TO4_CNT_EN
  output logic [3:0][15:0]           o_cnt,
`endif
  output logic [3:0][DATA_WIDTH-1:0] o_val
);

  demux_vec_t sel_c;
  demux_vec_t free_c;
  demux_vec_t load_c;

  // Destination decode and acceptance; o_ready is independent of i_valid.
  always_comb begin
    sel_c   = '0;
    o_ready = 1'b0;
    load_c  = '0;
    if (i_bcast) begin
      sel_c   = '1;
      o_ready = ~i_rst & (&free_c);
    end else begin
      sel_c   = demux_onehot(i_key);
      o_ready = ~i_rst & free_c[i_key];
    end
    if (i_valid && o_ready) begin
      load_c = sel_c;
    end
  end

  for (genvar n = 0; n < DEMUX_CH_NUM; n++) begin : g_slot
    demux_slot #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_slot (
      .clk_i  (i_clk),
      .rst_i  (i_rst),
      .load_i (load_c[n]),
      .data_i (i_val),
      .ready_i(i_ready[n]),
      .valid_o(o_valid[n]),
      .val_o  (o_val[n]),
      .free_o (free_c[n])
    );
  end

`ifdef DEMUX_1TO4_CNT_EN
  localparam int unsigned CNT_W = 16;

  for (genvar n = 0; n < DEMUX_CH_NUM; n++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Count output transfers, saturating at all-ones.
    always_comb begin
      cnt_d = cnt_q;
      if (o_valid[n] && i_ready[n] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // Counter register.
    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign o_cnt[n] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Scoreboard bench for demux_1to4_reg (define DEMUX_1TO4_CNT_EN to cover counters).
module tb_demux_1to4_reg;

  localparam int unsigned DW = 32;

  logic               i_clk = 1'b0;
  logic               i_rst;
  logic               i_valid;
  logic               o_ready;
  logic [1:0]         i_key;
  logic               i_bcast;
  logic [DW-1:0]      i_val;
  logic [3:0]         o_valid;
  logic [3:0]         i_ready;
  logic [3:0][DW-1:0] o_val;
`ifdef DEMUX_1TO4_CNT_EN
  logic [3:0][15:0]   o_cnt;
`endif

  demux_1to4_reg #(.DATA_WIDTH(DW)) dut (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_valid(i_valid),
    .o_ready(o_ready),
    .i_key  (i_key),
    .i_bcast(i_bcast),
    .i_val  (i_val),
    .o_valid(o_valid),
    .i_ready(i_ready),
`ifdef DEMUX_1TO4_CNT_EN
    .o_cnt  (o_cnt),
`endif
    .o_val  (o_val)
  );

  always #5 i_clk = ~i_clk;

  int nchk = 0;
  int nerr = 0;

  // Reference model: per-channel FIFO of beats accepted but not yet consumed,
  // plus a saturating count of consumed beats.
  logic [DW-1:0] sbq [4][$];
  int            mcnt [4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit mfree(input int n);
    return (sbq[n].size() == 0) || (i_ready[n] == 1'b1);
  endfunction

  task automatic model_reset();
    for (int n = 0; n < 4; n++) begin
      sbq[n].delete();
      mcnt[n] = 0;
    end
  endtask

  // Monitor: every output transfer pops the expected beat and compares.
  always @(negedge i_clk) begin
    if (!i_rst) begin
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("o_valid[%0d]", n), 32'(o_valid[n]), 32'(sbq[n].size() != 0));
        if (sbq[n].size() != 0 && o_valid[n]) begin
          chk($sformatf("o_val[%0d]", n), 32'(o_val[n]), sbq[n][0]);
          if (i_ready[n]) begin
            void'(sbq[n].pop_front());
            mcnt[n] = (mcnt[n] < 65535) ? mcnt[n] + 1 : 65535;
          end
        end
      end
    end
  end

  // One cycle of stimulus; called at posedge+1, returns at next posedge+1.
  task automatic step(input logic v, input logic [1:0] k, input logic b,
                      input logic [DW-1:0] d, input logic [3:0] r,
                      output logic acc, output logic rdy);
    logic exp_rdy;
    i_valid = v; i_key = k; i_bcast = b; i_val = d; i_ready = r;
    @(negedge i_clk); #1;
    exp_rdy = b ? (mfree(0) && mfree(1) && mfree(2) && mfree(3)) : mfree(int'(k));
    rdy = o_ready;
    chk("o_ready", 32'(o_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge i_clk);
    if (acc) begin
      for (int n = 0; n < 4; n++) begin
        if (b || (int'(k) == n)) sbq[n].push_back(d);
      end
    end
    #1;
  endtask

  task automatic send(input logic [1:0] k, input logic b, input logic [DW-1:0] d,
                      input logic [3:0] r);
    logic acc, rdy;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(1'b1, k, b, d, r, acc, rdy);
    if (!acc) chk("send_timeout", 32'(acc), 32'd1);
  endtask

  task automatic idle(input logic [3:0] r);
    logic acc, rdy;
    step(1'b0, 2'd0, 1'b0, '0, r, acc, rdy);
  endtask

  task automatic do_reset();
    i_rst = 1'b1;
    model_reset();
    @(posedge i_clk); @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  initial begin
    logic acc, rdy;
    i_rst = 1'b1; i_valid = 1'b1; i_key = 2'd0; i_bcast = 1'b0; i_val = '0; i_ready = 4'hF;
    model_reset();
    @(posedge i_clk); @(posedge i_clk); #1;
    chk("rst_o_valid", 32'(o_valid), 32'h0);
    chk("rst_o_ready", 32'(o_ready), 32'h0);
    chk("rst_o_val", 32'(o_val[0] | o_val[1] | o_val[2] | o_val[3]), 32'h0);
    i_rst = 1'b0; i_valid = 1'b0;

    // Reset in the middle of a held beat.
    send(2'd2, 1'b0, 32'hDEADBEEF, 4'b0000);
    chk("hold_val2", o_val[2], 32'hDEADBEEF);
    #3;
    i_valid = 1'b1; i_key = 2'd2; i_rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_valid", 32'(o_valid), 32'h0);
    chk("async_rst_val2", o_val[2], 32'h0);
    chk("async_rst_ready", 32'(o_ready), 32'h0);
    @(posedge i_clk); #1;
    i_rst = 1'b0; i_valid = 1'b0;

    // Back-to-back unicast stream to channel 1.
    for (int i = 1; i <= 3; i++) begin
      step(1'b1, 2'd1, 1'b0, DW'(i), 4'b1111, acc, rdy);
      chk("stream_rdy", 32'(rdy), 32'd1);
      chk("stream_valid", 32'(o_valid), 32'b0010);
      chk("stream_val1", o_val[1], 32'(i));
    end
    idle(4'b1111);

    // Backpressure on channel 0.
    send(2'd0, 1'b0, 32'd5, 4'b1110);
    step(1'b1, 2'd0, 1'b0, 32'd6, 4'b1110, acc, rdy);
    chk("bp_stall_rdy", 32'(rdy), 32'd0);
    chk("bp_hold_val0", o_val[0], 32'd5);
    step(1'b1, 2'd0, 1'b0, 32'd6, 4'b1111, acc, rdy);
    chk("bp_release_rdy", 32'(rdy), 32'd1);
    chk("bp_val0", o_val[0], 32'd6);
    chk("bp_valid0", 32'(o_valid[0]), 32'd1);
    idle(4'b1111);

    // Stalled channel 3 does not block unicast to channel 0.
    send(2'd3, 1'b0, 32'd33, 4'b0111);
    step(1'b1, 2'd0, 1'b0, 32'd7, 4'b0110, acc, rdy);
    chk("indep_rdy", 32'(rdy), 32'd1);
    chk("indep_valid", 32'(o_valid), 32'b1001);

    // Broadcast blocked by full, stalled channel 2.
    send(2'd2, 1'b0, 32'h22, 4'b0001);
    step(1'b1, 2'd0, 1'b1, 32'hA5A5A5A5, 4'b1011, acc, rdy);
    chk("bc_stall_rdy", 32'(rdy), 32'd0);
    step(1'b1, 2'd0, 1'b1, 32'hA5A5A5A5, 4'b1111, acc, rdy);
    chk("bc_rdy", 32'(rdy), 32'd1);
    chk("bc_valid", 32'(o_valid), 32'hF);
    for (int n = 0; n < 4; n++) chk("bc_val", o_val[n], 32'hA5A5A5A5);
    idle(4'b1111);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), 2'($urandom), ($urandom_range(0, 7) == 0),
           $urandom, 4'($urandom), acc, rdy);
    end
    idle(4'b1111);
    idle(4'b1111);
    for (int n = 0; n < 4; n++) chk("drained_empty", 32'(sbq[n].size()), 32'd0);

`ifdef DEMUX_1TO4_CNT_EN
    do_reset();
    for (int i = 0; i < 3; i++) send(2'd1, 1'b0, 32'(i), 4'b1111);
    send(2'd0, 1'b1, 32'h0BCA57, 4'b1111);
    idle(4'b1111);
    idle(4'b1111);
    chk("cnt0", 32'(o_cnt[0]), 32'd1);
    chk("cnt1", 32'(o_cnt[1]), 32'd4);
    chk("cnt2", 32'(o_cnt[2]), 32'd1);
    chk("cnt3", 32'(o_cnt[3]), 32'd1);
    for (int i = 0; i < 65536; i++) step(1'b1, 2'd0, 1'b0, 32'(i), 4'b0001, acc, rdy);
    idle(4'b1111);
    idle(4'b1111);
    chk("cnt0_sat", 32'(o_cnt[0]), 32'h0000FFFF);
    for (int n = 0; n < 4; n++) chk("cnt_model", 32'(o_cnt[n]), 32'(mcnt[n]));
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
